// File: rtl/cad_result_pkg.sv
// cad_result_pkg: shared word width, CAD frame lengths and FIFO entry types
package cad_result_pkg;
  localparam int WORD_W = 20;
  localparam int CONV_S = 4;
  localparam int CONV_M = 36;
  localparam int CONV_L = 196;
  localparam int DECONV_S = 144;
  localparam int DECONV_M = 400;
  localparam int DECONV_L = 1296;
  typedef logic [WORD_W-1:0] word_t;
  typedef struct packed {
    logic  last;
    word_t data;
  } fifo_entry_t;
endpackage

// File: rtl/cad_word_fifo.sv
// cad_word_fifo: synchronous FIFO whose head output holds its last value while empty
module cad_word_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [W-1:0] hold;
  logic do_push, do_pop;
  // status, gated handshakes and head selection
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count = wr_ptr - rd_ptr;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    head = empty ? hold : mem[rd_ptr[AW-1:0]];
  end
  // pointers and the held copy of the head
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      hold <= head;
    end
  end
  // storage array, contents need no reset since reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/cad_result_deser.sv
// cad_result_deser: serial CAD result to framed parallel words; CAD_RESULT_DESER_CHECKSUM_EN adds a per-frame sum
module cad_result_deser #(
  parameter int WORD_W = cad_result_pkg::WORD_W,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ser_valid,
  input  logic                          ser_bit,
  input  logic                          word_ready,
  output logic                          word_valid,
  output logic [WORD_W-1:0]             word_data,
  output logic                          word_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic [CNT_W-1:0]              frame_words,
  output logic                          ovf_err,
  output logic                          frag_err,
  input  logic                          err_clr
`ifdef CAD_RESULT_DESER_CHECKSUM_EN
  ,
  output logic [WORD_W+CNT_W-1:0]       frame_sum,
  output logic                          frame_sum_valid
`endif
);
  localparam int BC_W = $clog2(WORD_W);
  logic [BC_W-1:0] bit_cnt;
  logic [WORD_W-1:0] shreg, pend_data;
  logic pend_vld;
  logic [CNT_W-1:0] frm_cnt;
  logic push_q;
  logic [WORD_W:0] push_entry, head;
  logic full, empty;
  logic done, close, frag, pop, ovf;
  // word completion, frame close, fragment and overflow events
  always_comb begin
    done = ser_valid && bit_cnt == BC_W'(WORD_W - 1);
    close = pend_vld && !ser_valid;
    frag = !ser_valid && bit_cnt != '0;
    pop = word_valid && word_ready;
    ovf = push_q && full && !pop;
  end
  // shift register, pending word, frame counting and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg <= '0;
      pend_vld <= 1'b0;
      pend_data <= '0;
      frm_cnt <= '0;
      frame_words <= '0;
      push_q <= 1'b0;
      push_entry <= '0;
      ovf_err <= 1'b0;
      frag_err <= 1'b0;
    end else begin
      if (ser_valid) begin
        shreg <= {shreg[WORD_W-2:0], ser_bit};
        bit_cnt <= done ? '0 : bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end
      if (done) pend_data <= {shreg[WORD_W-2:0], ser_bit};
      pend_vld <= done;
      push_q <= pend_vld;
      push_entry <= {close, pend_data};
      if (pend_vld) frm_cnt <= close ? '0 : frm_cnt + 1'b1;
      if (close) frame_words <= frm_cnt + 1'b1;
      ovf_err <= ovf || (ovf_err && !err_clr);
      frag_err <= frag || (frag_err && !err_clr);
    end
  end
`ifdef CAD_RESULT_DESER_CHECKSUM_EN
  logic [WORD_W+CNT_W-1:0] sum_acc, next_sum;
  // running sum including the word being resolved
  always_comb begin
    next_sum = sum_acc + (WORD_W+CNT_W)'(pend_data);
  end
  // accumulate every resolved word, publish and restart at frame close
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc <= '0;
      frame_sum <= '0;
      frame_sum_valid <= 1'b0;
    end else begin
      frame_sum_valid <= close;
      if (pend_vld) sum_acc <= close ? '0 : next_sum;
      if (close) frame_sum <= next_sum;
    end
  end
`endif
  cad_word_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W + 1)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push_q),
    .push_data(push_entry),
    .pop(pop),
    .head(head),
    .full(full),
    .empty(empty),
    .count(fifo_cnt)
  );
  assign word_valid = !empty;
  assign word_last = head[WORD_W];
  assign word_data = head[WORD_W-1:0];
endmodule

// File: tb/tb_cad_result_deser.sv
// tb_cad_result_deser: directed scenario bench for cad_result_deser
module tb_cad_result_deser;
  import cad_result_pkg::*;
  logic clk = 1'b0;
  logic rst, ser_valid, ser_bit, word_ready, err_clr;
  logic word_valid, word_last, ovf_err, frag_err;
  logic [WORD_W-1:0] word_data;
  logic [4:0] fifo_cnt;
  logic [10:0] frame_words;
`ifdef CAD_RESULT_DESER_CHECKSUM_EN
  logic [30:0] frame_sum;
  logic frame_sum_valid;
  int sum_cyc[$];
  logic [30:0] sum_val[$];
  logic [10:0] sum_fw[$];
`endif
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [WORD_W:0] got_q[$];
  int got_cyc[$];

  cad_result_deser dut (
    .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_bit(ser_bit),
    .word_ready(word_ready), .word_valid(word_valid), .word_data(word_data),
    .word_last(word_last), .fifo_cnt(fifo_cnt), .frame_words(frame_words),
    .ovf_err(ovf_err), .frag_err(frag_err), .err_clr(err_clr)
`ifdef CAD_RESULT_DESER_CHECKSUM_EN
    , .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (word_valid && word_ready) begin
      got_q.push_back({word_last, word_data});
      got_cyc.push_back(cyc);
    end
`ifdef CAD_RESULT_DESER_CHECKSUM_EN
    if (frame_sum_valid) begin
      sum_cyc.push_back(cyc);
      sum_val.push_back(frame_sum);
      sum_fw.push_back(frame_words);
    end
`endif
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
    $fatal(1);
  end

  task automatic send_word(input word_t w);
    for (int i = WORD_W - 1; i >= 0; i--) begin
      ser_valid = 1'b1;
      ser_bit = w[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    ser_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic word_t bp_word(input int i);
    return word_t'(32'h10000 + i * 32'h123);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    n_chk++;
    if ({word_valid, word_last, word_data, fifo_cnt, frame_words, ovf_err, frag_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b l=%b d=%h cnt=%0d fw=%0d ovf=%b frag=%b, want all 0",
               word_valid, word_last, word_data, fifo_cnt, frame_words, ovf_err, frag_err);
    end
  endtask

  task automatic test_single_frame;
    word_t w [4] = '{20'hABCDE, 20'h00001, 20'hFFFFF, 20'h80000};
    int fin [4];
    word_ready = 1'b1;
    got_q.delete();
    got_cyc.delete();
    for (int k = 0; k < CONV_S; k++) begin
      send_word(w[k]);
      fin[k] = cyc;
    end
    idle(6);
    n_chk++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL single_count: got %0d words, want 4", got_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (got_q[k] !== {k == 3, w[k]}) begin
          n_fail++;
          $display("FAIL single_word%0d: got last=%b data=%h, want last=%b data=%h",
                   k, got_q[k][WORD_W], got_q[k][WORD_W-1:0], k == 3, w[k]);
        end
        n_chk++;
        if (got_cyc[k] != fin[k] + 2) begin
          n_fail++;
          $display("FAIL single_latency%0d: valid at edge %0d, want %0d", k, got_cyc[k], fin[k] + 2);
        end
      end
    end
    n_chk++;
    if (frame_words !== 11'd4) begin
      n_fail++;
      $display("FAIL single_frame_words: got %0d, want 4", frame_words);
    end
  endtask

  task automatic test_backpressure;
    word_ready = 1'b0;
    for (int k = 0; k < CONV_M; k++) send_word(bp_word(k));
    idle(5);
    n_chk++;
    if ({fifo_cnt, ovf_err, word_valid, frame_words} !== {5'd16, 1'b1, 1'b1, 11'd36}) begin
      n_fail++;
      $display("FAIL bp_full: got cnt=%0d ovf=%b v=%b fw=%0d, want cnt=16 ovf=1 v=1 fw=36",
               fifo_cnt, ovf_err, word_valid, frame_words);
    end
    got_q.delete();
    got_cyc.delete();
    word_ready = 1'b1;
    idle(20);
    word_ready = 1'b0;
    n_chk++;
    if (got_q.size() != 16) begin
      n_fail++;
      $display("FAIL bp_drain_count: got %0d words, want 16", got_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_chk++;
        if (got_q[k] !== {1'b0, bp_word(k)}) begin
          n_fail++;
          $display("FAIL bp_word%0d: got %h, want %h", k, got_q[k], {1'b0, bp_word(k)});
        end
      end
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    n_chk++;
    if ({ovf_err, fifo_cnt} !== 6'd0) begin
      n_fail++;
      $display("FAIL bp_clear: got ovf=%b cnt=%0d, want ovf=0 cnt=0", ovf_err, fifo_cnt);
    end
  endtask

  task automatic test_fragment;
    word_t w [4] = '{20'h12345, 20'h6789A, 20'hBCDEF, 20'h00F0F};
    word_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      ser_valid = 1'b1;
      ser_bit = 1'b1;
      @(posedge clk); #1;
    end
    idle(4);
    n_chk++;
    if ({frag_err, fifo_cnt, word_valid} !== {1'b1, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL frag_flag: got frag=%b cnt=%0d v=%b, want frag=1 cnt=0 v=0", frag_err, fifo_cnt, word_valid);
    end
    got_q.delete();
    got_cyc.delete();
    for (int k = 0; k < 4; k++) send_word(w[k]);
    idle(6);
    n_chk++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL frag_count: got %0d words, want 4", got_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (got_q[k] !== {k == 3, w[k]}) begin
          n_fail++;
          $display("FAIL frag_word%0d: got %h, want %h", k, got_q[k], {k == 3, w[k]});
        end
      end
    end
    n_chk++;
    if ({frame_words, frag_err} !== {11'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL frag_after: got fw=%0d frag=%b, want fw=4 frag=1", frame_words, frag_err);
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    n_chk++;
    if (frag_err !== 1'b0) begin
      n_fail++;
      $display("FAIL frag_clear: got %b, want 0", frag_err);
    end
  endtask

  task automatic test_push_pop_full;
    word_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_word(word_t'(32'h20000 + k));
    idle(4);
    n_chk++;
    if ({fifo_cnt, ovf_err} !== {5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL ppf_fill: got cnt=%0d ovf=%b, want cnt=16 ovf=0", fifo_cnt, ovf_err);
    end
    send_word(20'hCAFE5);
    ser_valid = 1'b0;
    @(posedge clk); #1;
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    n_chk++;
    if ({fifo_cnt, ovf_err, word_data} !== {5'd16, 1'b0, 20'h20001}) begin
      n_fail++;
      $display("FAIL ppf_same_cycle: got cnt=%0d ovf=%b head=%h, want cnt=16 ovf=0 head=20001",
               fifo_cnt, ovf_err, word_data);
    end
    got_q.delete();
    got_cyc.delete();
    word_ready = 1'b1;
    idle(20);
    n_chk++;
    if (got_q.size() != 16) begin
      n_fail++;
      $display("FAIL ppf_drain_count: got %0d words, want 16", got_q.size());
    end else begin
      n_chk++;
      if ({got_q[0], got_q[15]} !== {1'b0, 20'h20001, 1'b1, 20'hCAFE5}) begin
        n_fail++;
        $display("FAIL ppf_drain_ends: got first=%h last=%h, want first=020001 last=1cafe5", got_q[0], got_q[15]);
      end
    end
    n_chk++;
    if (frame_words !== 11'd1) begin
      n_fail++;
      $display("FAIL ppf_frame_words: got %0d, want 1", frame_words);
    end
  endtask

  task automatic test_reset_mid_frame;
    int n_last;
    word_ready = 1'b0;
    for (int k = 0; k < 100; k++) send_word(word_t'(k + 1));
    n_chk++;
    if ({fifo_cnt, ovf_err} !== {5'd16, 1'b1}) begin
      n_fail++;
      $display("FAIL rmid_before: got cnt=%0d ovf=%b, want cnt=16 ovf=1", fifo_cnt, ovf_err);
    end
    rst = 1'b1;
    ser_bit = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ser_valid = 1'b0;
    n_chk++;
    if ({word_valid, word_last, word_data, fifo_cnt, frame_words, ovf_err, frag_err} !== '0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got v=%b l=%b d=%h cnt=%0d fw=%0d ovf=%b frag=%b, want all 0",
               word_valid, word_last, word_data, fifo_cnt, frame_words, ovf_err, frag_err);
    end
    got_q.delete();
    got_cyc.delete();
    word_ready = 1'b1;
    for (int k = 0; k < DECONV_S; k++) send_word(word_t'(32'h30000 + k));
    idle(6);
    n_last = 0;
    foreach (got_q[k]) n_last += int'(got_q[k][WORD_W]);
    n_chk++;
    if (got_q.size() != DECONV_S || n_last != 1 || frame_words !== 11'd144) begin
      n_fail++;
      $display("FAIL rmid_fresh_frame: got words=%0d lasts=%0d fw=%0d, want words=144 lasts=1 fw=144",
               got_q.size(), n_last, frame_words);
    end else begin
      n_chk++;
      if ({got_q[0], got_q[143]} !== {1'b0, 20'h30000, 1'b1, 20'h3008F}) begin
        n_fail++;
        $display("FAIL rmid_fresh_ends: got first=%h last=%h, want 030000 13008f", got_q[0], got_q[143]);
      end
    end
  endtask

`ifdef CAD_RESULT_DESER_CHECKSUM_EN
  task automatic test_checksum;
    int fin;
    word_ready = 1'b1;
    sum_cyc.delete();
    sum_val.delete();
    sum_fw.delete();
    for (int k = 1; k <= 4; k++) send_word(word_t'(k));
    fin = cyc;
    n_chk++;
    if (frame_words !== 11'd144) begin
      n_fail++;
      $display("FAIL sum_fw_before: got %0d, want 144", frame_words);
    end
    idle(6);
    n_chk++;
    if (sum_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL sum_pulse_count: got %0d pulses, want 1", sum_cyc.size());
    end else begin
      n_chk++;
      if (sum_cyc[0] != fin + 1 || sum_val[0] !== 31'd10 || sum_fw[0] !== 11'd4) begin
        n_fail++;
        $display("FAIL sum_pulse: got edge=%0d sum=%0d fw=%0d, want edge=%0d sum=10 fw=4",
                 sum_cyc[0], sum_val[0], sum_fw[0], fin + 1);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    ser_valid = 1'b0;
    ser_bit = 1'b0;
    word_ready = 1'b0;
    err_clr = 1'b0;
    #1;
    test_reset;
    test_single_frame;
    test_backpressure;
    test_fragment;
    test_push_pop_full;
    test_reset_mid_frame;
`ifdef CAD_RESULT_DESER_CHECKSUM_EN
    test_checksum;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cad_result_deser.md
Name: cad_result_deser

Overview:
- Downstream consumer of the CAD core's serial result port (out_valid/out_value).
- The core emits each 20-bit result MSB-first, one bit per cycle, back-to-back for a whole frame.
  - Frame sizes: 4/36/196 words for conv, 144/400/1296 for deconv.
- This block reassembles the bits into parallel words, marks the last word of each frame, and buffers words in a small FIFO behind a valid/ready port.
- It feeds the result writeback/compare logic.

Parameters:
- WORD_W, 20, bits per result word.
- FIFO_DEPTH, 16, word FIFO entries (power of two, >= 2).
- CNT_W, 11, width of the per-frame word counter (max 1296 words).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ser_valid  in  1  serial stream valid (CAD core out_valid).
- ser_bit  in  1  serial data bit, MSB of each word first (CAD core out_value).
- word_ready  in  1  downstream accepts a word this cycle.
- word_valid  out  1  FIFO head is valid.
- word_data  out  WORD_W  FIFO head word.
- word_last  out  1  FIFO head is the final word of its frame.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_words  out  CNT_W  word count of the most recently closed frame.
- ovf_err  out  1  sticky: a word was dropped because the FIFO was full.
- frag_err  out  1  sticky: ser_valid fell mid-word.
- err_clr  in  1  clears ovf_err and frag_err.

Behaviour:
- Reset (rst=1 at an edge):
  - word_valid, word_last, ovf_err, frag_err = 0.
  - word_data = 0, fifo_cnt = 0, frame_words = 0.
  - Bit counter, shift register, pending register and FIFO pointers all cleared.
  - Reset mid-frame discards all partial and buffered data.
- Shift:
  - Each cycle with ser_valid=1: shreg <= {shreg[WORD_W-2:0], ser_bit}; bit_cnt increments 0..WORD_W-1 and wraps.
- Word complete:
  - When the WORD_W-th bit is sampled (bit_cnt==WORD_W-1), the assembled word is loaded into the pending register (pend_vld=1).
  - bit_cnt wraps to 0.
- Pending resolution, on the cycle after pend_vld is set:
  - If ser_valid=1: push the pending word with last=0.
  - If ser_valid=0: push it with last=1, latch frame_words = words in frame including this one, and reset the frame counter.
  - pend_vld clears unless a new word completes in the same cycle. With continuous streaming this cannot happen, because 20 bits separate completions.
- Latency: the word is pushed at the edge after it completes. word_valid rises 2 edges after the edge that sampled the final bit (FIFO previously empty).
- Fragment: ser_valid=0 with bit_cnt!=0 → partial bits discarded, bit_cnt=0, frag_err=1. A pending word still resolves with last=1.
- Idle gaps: ser_valid low with bit_cnt==0 and no pending word → no state change. A new frame starts at the next ser_valid high.
- FIFO:
  - Pop when word_valid && word_ready.
  - Push and pop in the same cycle are both honoured, including when full or empty. When empty, the pushed word appears next cycle, never combinationally.
  - Push while full with no pop → word dropped, ovf_err=1, fifo_cnt unchanged. If the dropped word was last, frame_words still updates.
- Outputs: word_data and word_last are driven from the FIFO head. When word_valid=0 they hold their previous value.
- err_clr: clears the sticky flags next edge. An error event in the same cycle wins and the flag stays 1.

Optional Feature:
- Macro: CAD_RESULT_DESER_CHECKSUM_EN.
- When defined, two extra outputs:
  - frame_sum (WORD_W+CNT_W bits): unsigned sum of every word resolved in the frame, including words dropped by overflow.
  - frame_sum_valid: one-cycle pulse on the edge frame_words updates.
  - The accumulator clears on reset and after each frame close.
- When undefined: neither port nor the accumulator exists, and behaviour is otherwise identical.

Decomposition:
- Package cad_result_pkg holds:
  - WORD_W and the per-mode frame length constants (4, 36, 196, 144, 400, 1296).
  - A typedef for word data.
  - A typedef for the FIFO entry struct {last, data}.
- One sub-module, cad_word_fifo: synchronous FIFO, parameterised depth/width, exposing full/empty/count.
- The deserializer and pending logic stay in the top module.

Test Plan:
- Single conv frame: 4 words 0xABCDE, 0x00001, 0xFFFFF, 0x80000 streamed with word_ready=1 → word_valid high 2 cycles after each final bit; words match in order; word_last only on 0x80000; frame_words=4.
- Backpressure: 36-word frame with word_ready=0 throughout → FIFO holds 16 words, fifo_cnt=16, ovf_err=1; the first 16 words are intact after word_ready rises.
- Fragment: 9 bits then ser_valid low → frag_err=1, no word pushed. A following 4-word frame is assembled correctly.
- Simultaneous push/pop at full: FIFO full, word_ready=1 while a word resolves → no drop, fifo_cnt stays 16, ovf_err stays 0.
- Reset mid-frame: rst=1 after word 100 of a 400-word frame → all outputs 0 next edge. A fresh 144-word frame then gives frame_words=144.
- Checksum (macro defined): words 1, 2, 3, 4 → frame_sum=10 with a one-cycle frame_sum_valid coincident with the frame_words update.
